// File: rtl/riscv_dmem_unit.sv
// Data-memory unit for the RISC-V MEM stage: Funct3-decoded loads/stores with lane placement,
// sign/zero extension, alignment checks and a valid/ready handshake with fixed response latency.
module riscv_dmem_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              wr,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);
    localparam int NB = DATA_W / 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q;
    logic [1:0]          cnt_q;
    logic                err_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [7:0]          mem [2**ADDR_W];

    logic                accept;
    logic                legal;
    logic                aligned;
    logic                err_d;
    logic [1:0]          size;
    logic [3:0]          nbytes;
    logic                sign_bit;
    logic [DATA_W-1:0]   rdata_d;

    assign rsp_valid = (state_q == BUSY) && (cnt_q == 2'd0);
    assign req_ready = !reset && ((state_q == IDLE) || rsp_valid);
    assign accept    = req_valid && req_ready;

    // Funct3 legality and natural-alignment checks for the incoming request.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        legal   = 1'b0;
        aligned = 1'b0;
        size    = req_funct3[1:0];
        nbytes  = 4'd1 << size;
        unique case (req_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b011:                 legal = (DATA_W == 64);
            3'b100, 3'b101:         legal = !req_we;
            3'b110:                 legal = (DATA_W == 64) && !req_we;
            default:                legal = 1'b0;
        endcase
        unique case (size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = !req_addr[0];
            2'd2:    aligned = (req_addr[1:0] == 2'b00);
            default: aligned = (req_addr[2:0] == 3'b000);
        endcase
        err_d = !(legal && aligned);
    end

    // Little-endian gather; lanes above the access size are filled with the extension bit.
    always_comb begin
        rdata_d  = '0;
        sign_bit = !req_funct3[2] && mem[req_addr + ADDR_W'(nbytes - 4'd1)][7];
        for (int k = 0; k < NB; k++) begin
            rdata_d[8*k +: 8] = (k < int'(nbytes)) ? mem[req_addr + ADDR_W'(k)] : {8{sign_bit}};
        end
        if (err_d || req_we) begin
            rdata_d = '0;
        end
    end

    // NOTE: the storage array is deliberately left without a reset; only control state is reset.
    always_ff @(posedge clk) begin
        if (accept && req_we && !err_d) begin
            for (int k = 0; k < NB; k++) begin
                if (k < int'(nbytes)) begin
                    mem[req_addr + ADDR_W'(k)] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            state_q <= BUSY;
            cnt_q   <= 2'(LATENCY - 1);
            err_q   <= err_d;
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= rdata_d;
        end else if (state_q == BUSY) begin
            if (cnt_q == 2'd0) begin
                state_q <= IDLE;
            end else begin
                cnt_q <= cnt_q - 2'd1;
            end
        end
    end

    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign wr        = rsp_valid && !err_q && we_q;
    assign rd        = rsp_valid && !err_q && !we_q;
    assign addr      = (wr || rd) ? addr_q : '0;
    assign wr_data   = wr ? wdata_q : '0;
    assign rd_data   = rd ? rdata_q : '0;

endmodule
